pipeline_skid_barrier: RTL

Parametrised pipeline-stage barrier with a valid/ready handshake and a two-entry skid buffer. It carries a data payload and a control bundle between adjacent pipeline stages, for example EX→MEM or MEM→WB. Downstream back-pressure is absorbed without a combinational path from `outReady` to `inReady`. A synchronous flush inserts a bubble by clearing the control fields only; payload data is left as is.

---
 rtl/pipeline_skid_barrier.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipeline_skid_barrier.sv
// pipeline_skid_barrier: pipeline-stage register with a valid/ready handshake
// and a two-entry skid buffer (main + skid). It carries a data payload and a
// control bundle between adjacent pipeline stages. A flush inserts a bubble by
// resetting the control fields and leaves the payload registers untouched.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   flush      synchronous bubble insertion, active-high
//   inValid    upstream beat present
//   inReady    registered; the barrier accepts a beat this cycle
//   inData     upstream payload     (DATA_WIDTH)
//   inCtrl     upstream control     (CTRL_WIDTH)
//   outValid   head entry valid (registered)
//   outReady   downstream accepts; low means stall
//   outData    head payload         (register output)
//   outCtrl    head control         (register output)
//   occupancy  number of held entries: 0, 1 or 2
module pipeline_skid_barrier #(
  parameter int unsigned            DATA_WIDTH = 69,
  parameter int unsigned            CTRL_WIDTH = 4,
  parameter logic [CTRL_WIDTH-1:0]  CTRL_RESET = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic [CTRL_WIDTH-1:0] inCtrl,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic [CTRL_WIDTH-1:0] outCtrl,
  output logic [1:0]            occupancy
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    in_ready_q;
  logic [DATA_WIDTH-1:0]   main_data_q, main_data_d;
  logic [CTRL_WIDTH-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0]   skid_ctrl_q, skid_ctrl_d;

  logic accept_c;
  logic emit_c;

  assign accept_c = inValid && in_ready_q;
  assign emit_c   = (state_q != EMPTY) && outReady;

  // Next-state and storage update.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      // Bubble: drop everything held or arriving, keep payload bits as is.
      state_d     = EMPTY;
      main_ctrl_d = CTRL_RESET;
      skid_ctrl_d = CTRL_RESET;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept_c) begin
            state_d     = HALF;
            main_data_d = inData;
            main_ctrl_d = inCtrl;
          end
        end
        HALF: begin
          if (accept_c && emit_c) begin
            main_data_d = inData;
            main_ctrl_d = inCtrl;
          end else if (accept_c) begin
            state_d     = FULL;
            skid_data_d = inData;
            skid_ctrl_d = inCtrl;
          end else if (emit_c) begin
            // An empty head must present the reset control value.
            state_d     = EMPTY;
            main_ctrl_d = CTRL_RESET;
          end
        end
        FULL: begin
          // inReady is low here, so only the drain case applies.
          if (emit_c) begin
            state_d     = HALF;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = CTRL_RESET;
          skid_ctrl_d = CTRL_RESET;
        end
      endcase
    end
  end

  // State register; reset overrides flush and handshakes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_RESET;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_RESET;
    end else begin
      state_q     <= state_d;
      // Registered from next state: no outReady -> inReady combinational path.
      in_ready_q  <= (state_d != FULL);
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign inReady   = in_ready_q;
  assign outValid  = (state_q != EMPTY);
  assign outData   = main_data_q;
  assign outCtrl   = main_ctrl_q;
  assign occupancy = state_q;

endmodule
